// File: rtl/rtc_bus_controller.sv
// ============================================================================
// rtc_bus_controller: RTC multiplexed A/D bus sequencer, processor + refresh arbiter.
// Auto-refresh timer/shadow buffer built only with RTC_AUTO_REFRESH_EN. Rev 1.0
// ============================================================================
`default_nettype none

module rtc_bus_controller #(
  parameter int unsigned T_PHASE      = 10,
  parameter int unsigned REFRESH_DIV  = 1000000,
  parameter logic [7:0]  REFRESH_BASE = 8'h21,
  parameter int unsigned REFRESH_CNT  = 3,
  parameter logic [7:0]  ADDR_PORT    = 8'h10,
  parameter logic [7:0]  DATA_PORT    = 8'h11,
  parameter logic [7:0]  CMD_PORT     = 8'h12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_write_strobe,
  input  logic [7:0]                 i_por_id,
  input  logic [7:0]                 i_out_port,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_drop,
  output logic [7:0]                 o_rd_data,
  output logic [8*REFRESH_CNT-1:0]   o_shadow,
  output logic                       o_shadow_valid,
  output logic                       o_shadow_upd,
  output logic                       o_rtc_cs_n,
  output logic                       o_rtc_rd_n,
  output logic                       o_rtc_wr_n,
  output logic                       o_rtc_ad,
  output logic [7:0]                 o_ad_out,
  output logic                       o_ad_oe,
  input  logic [7:0]                 i_ad_in
);

  localparam int unsigned PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [PW-1:0] c_ph_last   = PW'(T_PHASE - 1);
  localparam logic [PW-1:0] c_ph_penult = PW'(T_PHASE - 2);
  localparam logic [2:0]    c_last_byte = 3'(REFRESH_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SETUP, S_A_STROBE, S_A_HOLD,
    S_D_SETUP, S_D_STROBE, S_D_HOLD, S_RECOVER
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_phase;
  logic [7:0]    r_addr_reg, r_data_reg, r_tx_addr, r_tx_data, r_rx, r_rd_data;
  logic [7:0]    w_addr_nxt, w_data_nxt, r_ad_out;
  logic [2:0]    r_byte_idx;
  logic          r_cmd_wr, r_proc_req, r_busy, r_done, r_drop;
  logic          r_is_ref, r_wr, w_wr_nxt;
  logic          r_cs_n, r_rd_n, r_wr_n, r_rtc_ad, r_ad_oe;
  logic          w_last, w_commit, w_more, w_cmd_hit, w_ref_pend;
  logic          w_grant_proc, w_grant_ref, w_sample;

  assign w_last    = (r_phase == c_ph_last);
  assign w_commit  = (r_state == S_RECOVER) && (r_phase == c_ph_penult);
  assign w_more    = r_is_ref && (r_byte_idx != c_last_byte);
  assign w_cmd_hit = i_write_strobe && (i_por_id == CMD_PORT);
  assign w_sample  = (r_state == S_D_STROBE) && w_last;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_proc = 1'b0;
    w_grant_ref  = 1'b0;
    w_wr_nxt     = r_wr;
    w_addr_nxt   = r_tx_addr;
    w_data_nxt   = r_tx_data;
    case (r_state)
      S_IDLE: begin
        // Processor has priority; transaction context is frozen at grant.
        if (r_proc_req) begin
          w_grant_proc = 1'b1;
          w_state_nxt  = S_A_SETUP;
          w_wr_nxt     = r_cmd_wr;
          w_addr_nxt   = r_addr_reg;
          w_data_nxt   = r_data_reg;
        end else if (w_ref_pend) begin
          w_grant_ref  = 1'b1;
          w_state_nxt  = S_A_SETUP;
          w_wr_nxt     = 1'b0;
          w_addr_nxt   = REFRESH_BASE;
        end
      end
      S_A_SETUP:  if (w_last) w_state_nxt = S_A_STROBE;
      S_A_STROBE: if (w_last) w_state_nxt = S_A_HOLD;
      S_A_HOLD:   if (w_last) w_state_nxt = S_D_SETUP;
      S_D_SETUP:  if (w_last) w_state_nxt = S_D_STROBE;
      S_D_STROBE: if (w_last) w_state_nxt = S_D_HOLD;
      S_D_HOLD:   if (w_last) w_state_nxt = S_RECOVER;
      S_RECOVER: begin
        if (w_last) begin
          if (w_more) begin
            w_state_nxt = S_A_SETUP;
            w_addr_nxt  = r_tx_addr + 8'd1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_addr_reg <= 8'h00;
      r_data_reg <= 8'h00;
      r_tx_addr  <= 8'h00;
      r_tx_data  <= 8'h00;
      r_rx       <= 8'h00;
      r_rd_data  <= 8'h00;
      r_byte_idx <= 3'd0;
      r_cmd_wr   <= 1'b0;
      r_proc_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_is_ref   <= 1'b0;
      r_wr       <= 1'b0;
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_rtc_ad   <= 1'b0;
      r_ad_oe    <= 1'b0;
      r_ad_out   <= 8'h00;
    end else begin
      r_done <= 1'b0;
      r_drop <= 1'b0;
      if (i_write_strobe && (i_por_id == ADDR_PORT)) r_addr_reg <= i_out_port;
      if (i_write_strobe && (i_por_id == DATA_PORT)) r_data_reg <= i_out_port;
      if (w_cmd_hit) begin
        if (r_busy) begin
          r_drop <= 1'b1;
        end else begin
          r_proc_req <= 1'b1;
          r_busy     <= 1'b1;
          r_cmd_wr   <= i_out_port[0];
        end
      end
      if (w_grant_proc) begin
        r_proc_req <= 1'b0;
        r_is_ref   <= 1'b0;
      end
      if (w_grant_ref) begin
        r_is_ref   <= 1'b1;
        r_byte_idx <= 3'd0;
      end
      if ((r_state == S_RECOVER) && w_last && w_more) r_byte_idx <= r_byte_idx + 3'd1;

      r_state   <= w_state_nxt;
      r_phase   <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? '0 : r_phase + 1'b1;
      r_wr      <= w_wr_nxt;
      r_tx_addr <= w_addr_nxt;
      r_tx_data <= w_data_nxt;

      if (w_sample && !r_is_ref) r_rx <= i_ad_in;
      if (w_commit && !r_is_ref) begin
        r_done <= 1'b1;
        if (!r_wr) r_rd_data <= r_rx;
      end
      if ((r_state == S_RECOVER) && w_last && !r_is_ref) r_busy <= 1'b0;

      // Bus pins are decoded from the next state so they change on the state edge.
      r_cs_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rtc_ad <= 1'b0;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      case (w_state_nxt)
        S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
          r_cs_n   <= 1'b0;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr_nxt;
          if (w_state_nxt == S_A_STROBE) r_wr_n <= 1'b0;
        end
        S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
          r_cs_n   <= 1'b0;
          r_rtc_ad <= 1'b1;
          r_ad_oe  <= w_wr_nxt;
          r_ad_out <= w_wr_nxt ? w_data_nxt : 8'h00;
          if (w_state_nxt == S_D_STROBE) begin
            if (w_wr_nxt) r_wr_n <= 1'b0;
            else          r_rd_n <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RTC_AUTO_REFRESH_EN
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] c_div_last = RW'(REFRESH_DIV - 1);

  logic [RW-1:0]            r_ref_cnt;
  logic                     r_ref_pend, r_shadow_valid, r_shadow_upd;
  logic [8*REFRESH_CNT-1:0] r_stage, r_shadow;
  logic                     w_expire, w_burst_commit;

  assign w_expire       = (r_ref_cnt == c_div_last);
  assign w_burst_commit = w_commit && r_is_ref && !w_more;
  assign w_ref_pend     = r_ref_pend;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ref_cnt      <= '0;
      r_ref_pend     <= 1'b0;
      r_stage        <= '0;
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
      r_shadow_upd   <= 1'b0;
    end else begin
      r_shadow_upd <= 1'b0;
      r_ref_cnt    <= w_expire ? '0 : r_ref_cnt + 1'b1;
      // A fresh expiry outranks the clear, so a request is never lost.
      if (w_expire)            r_ref_pend <= 1'b1;
      else if (w_burst_commit) r_ref_pend <= 1'b0;
      if (w_sample && r_is_ref) begin
        for (int i = 0; i < int'(REFRESH_CNT); i++) begin
          if (r_byte_idx == 3'(i)) r_stage[8*i +: 8] <= i_ad_in;
        end
      end
      if (w_burst_commit) begin
        r_shadow       <= r_stage;
        r_shadow_upd   <= 1'b1;
        r_shadow_valid <= 1'b1;
      end
    end
  end

  assign o_shadow       = r_shadow;
  assign o_shadow_valid = r_shadow_valid;
  assign o_shadow_upd   = r_shadow_upd;
`else
  assign w_ref_pend     = 1'b0;
  assign o_shadow       = '0;
  assign o_shadow_valid = 1'b0;
  assign o_shadow_upd   = 1'b0;
`endif

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_drop     = r_drop;
  assign o_rd_data  = r_rd_data;
  assign o_rtc_cs_n = r_cs_n;
  assign o_rtc_rd_n = r_rd_n;
  assign o_rtc_wr_n = r_wr_n;
  assign o_rtc_ad   = r_rtc_ad;
  assign o_ad_out   = r_ad_out;
  assign o_ad_oe    = r_ad_oe;

endmodule

`default_nettype wire
